// File: rtl/frb_pkg.sv
// ---------------------------------------------------------------------------
// frb_pkg
// Shared definitions for the frb square strip: number of squares, the
// pixel colour constants and the IDLE/LOCKED state encoding.
// ---------------------------------------------------------------------------
package frb_pkg;

  localparam int NUM_FRB = 3;

  localparam logic [23:0] COL_OFF   = 24'h000000;  // not inside the strip
  localparam logic [23:0] COL_DIM   = 24'h808080;  // unselected square
  localparam logic [23:0] COL_LOCK  = 24'hFF0000;  // selected, cooling down
  localparam logic [23:0] COL_BLINK = 24'hFFFF00;  // selected, blink phase 1
  localparam logic [23:0] COL_SEL   = 24'hFFFFFF;  // selected, blink phase 0

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } frb_state_e;

endpackage

// File: rtl/frb_debounce.sv
// ---------------------------------------------------------------------------
// frb_debounce
// Two-flop synchroniser, counter debouncer and rising-edge detector for one
// raw push button.
//   clk     : pixel clock
//   rst_n   : asynchronous active-low reset
//   i_btn   : raw asynchronous button level (active high)
//   o_press : one-cycle pulse when the debounced level rises
// ---------------------------------------------------------------------------
module frb_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any cycle of agreement (a bounce back) clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/frb_square_colour.sv
// ---------------------------------------------------------------------------
// frb_square_colour
// Cursor / fire controller and pixel colouring for a strip of three squares.
//   clk, rst_n          : pixel clock, asynchronous active-low reset
//   frb_square_there    : pixel lies inside the strip
//   frb_select[1:0]     : square index under the pixel (3 = none)
//   frame_start         : one-cycle pulse per frame
//   btn_left/right/fire : raw push buttons
//   frb_rgb[23:0]       : strip colour, one clock after the pixel inputs
//   frb_rgb_valid       : frb_rgb overrides the background
//   cursor[1:0]         : highlighted square
//   fire_pulse          : one-cycle pulse on an accepted fire
//   fired_sel[1:0]      : cursor captured at the last accepted fire
// ---------------------------------------------------------------------------
module frb_square_colour
  import frb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLINK_FRAMES    = 15,
  parameter int LOCK_FRAMES     = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frb_square_there,
  input  logic [1:0]  frb_select,
  input  logic        frame_start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  output logic [23:0] frb_rgb,
  output logic        frb_rgb_valid,
  output logic [1:0]  cursor,
  output logic        fire_pulse,
  output logic [1:0]  fired_sel
);

  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam int LOCK_W  = $clog2(LOCK_FRAMES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_FRAMES - 1);
  localparam logic [1:0]         CUR_MAX    = 2'(NUM_FRB - 1);

  function automatic logic [23:0] pick_colour(
    input logic [1:0] sel,
    input logic [1:0] cur,
    input frb_state_e st,
    input logic       blink
  );
    if (sel != cur)          return COL_DIM;
    else if (st == ST_LOCKED) return COL_LOCK;
    else if (blink)           return COL_BLINK;
    else                      return COL_SEL;
  endfunction

  logic w_press_l, w_press_r, w_press_f;

  frb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_left),  .o_press(w_press_l));
  frb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_right), .o_press(w_press_r));
  frb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_fire),  .o_press(w_press_f));

  frb_state_e         r_state;
  frb_state_e         w_state_nxt;
  logic [1:0]         r_cursor;
  logic [1:0]         r_fired_sel;
  logic               r_fire_pulse;
  logic [LOCK_W-1:0]  r_lock_cnt;
  logic [BLINK_W-1:0] r_frame_cnt;
  logic               r_blink;
  logic [23:0]        r_rgb;
  logic               r_rgb_valid;

  logic w_lock_done;
  logic w_fire_accept;
  logic w_step_l;
  logic w_step_r;

  assign w_lock_done = (r_state == ST_LOCKED) && frame_start && (r_lock_cnt == LOCK_LAST);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_press_f)   w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_lock_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: a fire wins over any coincident move; in LOCKED every
  // press is simply dropped. Opposite moves in the same cycle cancel.
  always_comb begin
    w_fire_accept = 1'b0;
    w_step_l      = 1'b0;
    w_step_r      = 1'b0;
    if (r_state == ST_IDLE) begin
      w_fire_accept = w_press_f;
      w_step_l      = !w_press_f && w_press_l && !w_press_r;
      w_step_r      = !w_press_f && w_press_r && !w_press_l;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cursor     <= '0;
      r_fired_sel  <= '0;
      r_fire_pulse <= 1'b0;
      r_lock_cnt   <= '0;
    end else begin
      r_fire_pulse <= w_fire_accept;
      if (w_fire_accept) r_fired_sel <= r_cursor;
      if (w_step_l)      r_cursor <= (r_cursor == 2'd0) ? CUR_MAX : r_cursor - 2'd1;
      else if (w_step_r) r_cursor <= (r_cursor == CUR_MAX) ? 2'd0 : r_cursor + 2'd1;
      if (r_state != ST_LOCKED) r_lock_cnt <= '0;
      else if (frame_start)     r_lock_cnt <= w_lock_done ? '0 : r_lock_cnt + 1'b1;
    end
  end

  // Blink phase runs freely on frame_start, independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (frame_start) begin
      if (r_frame_cnt == BLINK_LAST) begin
        r_frame_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // Pixel path: one register stage, colour taken from the cursor/state
  // held before this edge's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb_valid <= 1'b0;
      r_rgb       <= COL_OFF;
    end else begin
      r_rgb_valid <= frb_square_there && (frb_select != 2'd3);
      r_rgb       <= (frb_square_there && (frb_select != 2'd3))
                     ? pick_colour(frb_select, r_cursor, r_state, r_blink)
                     : COL_OFF;
    end
  end

  assign frb_rgb       = r_rgb;
  assign frb_rgb_valid = r_rgb_valid;
  assign cursor        = r_cursor;
  assign fire_pulse    = r_fire_pulse;
  assign fired_sel     = r_fired_sel;

endmodule

// File: tb/tb_frb_square_colour.sv
module tb_frb_square_colour;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frb_square_there = 1'b0;
  logic [1:0]  frb_select = 2'd0;
  logic        frame_start = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_fire = 1'b0;
  logic [23:0] frb_rgb;
  logic        frb_rgb_valid;
  logic [1:0]  cursor;
  logic        fire_pulse;
  logic [1:0]  fired_sel;

  int n_checks = 0;
  int n_errors = 0;
  int fire_cnt = 0;

  frb_square_colour #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_FRAMES(2),
    .LOCK_FRAMES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .frb_square_there(frb_square_there), .frb_select(frb_select),
    .frame_start(frame_start),
    .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
    .frb_rgb(frb_rgb), .frb_rgb_valid(frb_rgb_valid),
    .cursor(cursor), .fire_pulse(fire_pulse), .fired_sel(fired_sel)
  );

  always #5 clk = ~clk;

  // Count fire pulses; a pulse longer than one cycle counts more than once.
  always @(negedge clk) if (fire_pulse === 1'b1) fire_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  typedef struct {
    logic        there;
    logic [1:0]  sel;
    int          fs;      // frame_start pulses issued before the pixel
    logic        exp_vld;
    logic [23:0] exp_rgb;
  } pix_vec_t;

  pix_vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic l, input logic r, input logic f, input int hold);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_fire = f;
    repeat (hold) @(negedge clk);
    btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic frame_pulse();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pixel(input string name, input logic there, input logic [1:0] sel,
                       input logic exp_vld, input logic [23:0] exp_rgb);
    @(negedge clk);
    frb_square_there = there;
    frb_select = sel;
    @(negedge clk);
    check({name, "_vld"}, 32'(frb_rgb_valid), 32'(exp_vld));
    check({name, "_rgb"}, 32'(frb_rgb), 32'(exp_rgb));
    frb_square_there = 1'b0;
    frb_select = 2'd0;
  endtask

  initial begin
    // cursor = 1, IDLE; blink phase tracked through the frame_start column
    vecs[0]  = '{1'b1, 2'd0, 0, 1'b1, 24'h808080};
    vecs[1]  = '{1'b1, 2'd1, 0, 1'b1, 24'hFFFFFF};
    vecs[2]  = '{1'b1, 2'd2, 0, 1'b1, 24'h808080};
    vecs[3]  = '{1'b1, 2'd3, 0, 1'b0, 24'h000000};
    vecs[4]  = '{1'b0, 2'd1, 0, 1'b0, 24'h000000};
    vecs[5]  = '{1'b1, 2'd1, 1, 1'b1, 24'hFFFFFF};  // 1st frame: phase 0
    vecs[6]  = '{1'b1, 2'd1, 1, 1'b1, 24'hFFFF00};  // 2nd frame: phase 1
    vecs[7]  = '{1'b1, 2'd0, 0, 1'b1, 24'h808080};
    vecs[8]  = '{1'b1, 2'd3, 0, 1'b0, 24'h000000};
    vecs[9]  = '{1'b1, 2'd1, 1, 1'b1, 24'hFFFF00};  // 3rd frame: phase 1
    vecs[10] = '{1'b1, 2'd1, 1, 1'b1, 24'hFFFFFF};  // 4th frame: phase 0

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cursor", 32'(cursor), 32'd0);
    check("rst_fired_sel", 32'(fired_sel), 32'd0);
    check("rst_fire_pulse", 32'(fire_pulse), 32'd0);
    check("rst_rgb", 32'(frb_rgb), 32'd0);
    check("rst_vld", 32'(frb_rgb_valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Right presses with wrap, then a glitch
    press(1'b0, 1'b1, 1'b0, 10);
    check("right1", 32'(cursor), 32'd1);
    press(1'b0, 1'b1, 1'b0, 10);
    check("right2", 32'(cursor), 32'd2);
    press(1'b0, 1'b1, 1'b0, 10);
    check("right_wrap", 32'(cursor), 32'd0);
    press(1'b0, 1'b1, 1'b0, 2);
    check("glitch", 32'(cursor), 32'd0);

    // Left wraps 0 -> 2, then back with right
    press(1'b1, 1'b0, 1'b0, 10);
    check("left_wrap", 32'(cursor), 32'd2);
    press(1'b0, 1'b1, 1'b0, 10);
    check("right_wrap2", 32'(cursor), 32'd0);

    // Simultaneous left+right
    press(1'b1, 1'b1, 1'b0, 10);
    check("lr_cursor", 32'(cursor), 32'd0);
    check("lr_nofire", 32'(fire_cnt), 32'd0);

    press(1'b0, 1'b1, 1'b0, 10);
    check("to_cursor1", 32'(cursor), 32'd1);

    // Pixel sweep and blink pattern
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < vecs[i].fs; k++) frame_pulse();
      pixel($sformatf("pix%0d", i), vecs[i].there, vecs[i].sel,
            vecs[i].exp_vld, vecs[i].exp_rgb);
    end

    // Fire and cooldown (blink counter now 0, phase 0)
    press(1'b0, 1'b1, 1'b0, 10);
    check("to_cursor2", 32'(cursor), 32'd2);
    press(1'b0, 1'b0, 1'b1, 10);
    check("fire1_cnt", 32'(fire_cnt), 32'd1);
    check("fire1_sel", 32'(fired_sel), 32'd2);
    pixel("locked_sel", 1'b1, 2'd2, 1'b1, 24'hFF0000);
    frame_pulse();
    press(1'b0, 1'b1, 1'b1, 10);
    check("locked_fire_drop", 32'(fire_cnt), 32'd1);
    check("locked_right_drop", 32'(cursor), 32'd2);
    frame_pulse();
    pixel("locked_blink1", 1'b1, 2'd2, 1'b1, 24'hFF0000);
    press(1'b0, 1'b0, 1'b1, 10);
    check("locked_fire_drop2", 32'(fire_cnt), 32'd1);
    frame_pulse();
    pixel("unlocked", 1'b1, 2'd2, 1'b1, 24'hFFFF00);
    press(1'b0, 1'b0, 1'b1, 10);
    check("fire2_cnt", 32'(fire_cnt), 32'd2);
    check("fire2_sel", 32'(fired_sel), 32'd2);

    // Asynchronous reset while LOCKED with cursor=2
    @(negedge clk);
    frb_square_there = 1'b1;
    frb_select = 2'd2;
    @(negedge clk);
    check("pre_rst_rgb", 32'(frb_rgb), 32'hFF0000);
    rst_n = 1'b0;
    #1;
    check("arst_cursor", 32'(cursor), 32'd0);
    check("arst_fired_sel", 32'(fired_sel), 32'd0);
    check("arst_fire_pulse", 32'(fire_pulse), 32'd0);
    check("arst_rgb", 32'(frb_rgb), 32'd0);
    check("arst_vld", 32'(frb_rgb_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    frb_select = 2'd0;
    @(negedge clk);
    check("post_rst_rgb", 32'(frb_rgb), 32'hFFFFFF);
    check("post_rst_vld", 32'(frb_rgb_valid), 32'd1);
    frb_square_there = 1'b0;
    press(1'b0, 1'b0, 1'b1, 10);
    check("post_rst_fire", 32'(fire_cnt), 32'd3);
    check("post_rst_fsel", 32'(fired_sel), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
